// File: rtl/spi_pkg.sv
// Shared SPI frame constants and bridge state encoding.
// The SPI master imports the same frame constants.
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } spi_state_e;

    localparam int FRAME_BITS    = 16;
    localparam int CMD_BITS      = 8;
    localparam int READ_FLAG_BIT = 7;
    localparam int CNT_W         = 5;

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage input synchronizer with registered rise/fall pulses.
// A pin edge shows up as a pulse STAGES+1 clocks later.
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic i_ck,
    input  logic i_rstn,
    input  logic i_din,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] chain_reg;
    logic              prev_reg;
    logic              rise_reg;
    logic              fall_reg;

    // Chain resets low so a CSN that is already low at reset release
    // never produces a falling edge; the frame in progress is ignored.
    always_ff @(posedge i_ck or negedge i_rstn) begin
        if (!i_rstn) begin
            chain_reg <= '0;
            prev_reg  <= 1'b0;
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
        end else begin
            chain_reg <= {chain_reg[STAGES-2:0], i_din};
            prev_reg  <= chain_reg[STAGES-1];
            rise_reg  <= chain_reg[STAGES-1] & ~prev_reg;
            fall_reg  <= ~chain_reg[STAGES-1] & prev_reg;
        end
    end

    assign o_sync = chain_reg[STAGES-1];
    assign o_rise = rise_reg;
    assign o_fall = fall_reg;

endmodule

// File: rtl/spi_reg_bridge.sv
// SPI mode-3 slave that turns each 16-bit command/data frame into a
// single local-bus write or read, returning read data on MISO.
module spi_reg_bridge
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 7
) (
    input  logic              i_ck,
    input  logic              i_rstn,
    input  logic              i_sclk,
    input  logic              i_csn,
    input  logic              i_mosi,
    output logic              o_miso,
    output logic              o_miso_oe,
    output logic [ADDR_W-1:0] o_bus_addr,
    output logic [7:0]        o_bus_wdata,
    output logic              o_bus_wr,
    output logic              o_bus_rd,
    input  logic [7:0]        i_bus_rdata,
    output logic              o_busy,
    output logic              o_frame_err
);

    logic sclk_rise;
    logic sclk_fall;
    logic sclk_s;
    logic csn_rise;
    logic csn_fall;
    logic csn_s;
    logic mosi_s;

    logic [SYNC_STAGES-1:0] mosi_sync_reg;

    spi_state_e        state_reg, state_next;
    logic [CNT_W-1:0]  bit_cnt_reg, bit_cnt_next;
    logic [7:0]        rx_reg, rx_next;
    logic [7:0]        tx_reg, tx_next;
    logic              miso_reg, miso_next;
    logic              overrun_reg, overrun_next;
    logic              cmd_rd_reg, cmd_rd_next;
    logic [ADDR_W-1:0] cmd_addr_reg, cmd_addr_next;
    logic [ADDR_W-1:0] bus_addr_reg, bus_addr_next;
    logic [7:0]        bus_wdata_reg, bus_wdata_next;
    logic              bus_wr_reg, bus_wr_next;
    logic              bus_rd_reg, bus_rd_next;
    logic              rd_dly_reg, rd_dly_next;
    logic              frame_err_reg, frame_err_next;
    logic              armed_reg, armed_next;
    logic [7:0]        rx_shift;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
        .i_ck   (i_ck),
        .i_rstn (i_rstn),
        .i_din  (i_sclk),
        .o_sync (sclk_s),
        .o_rise (sclk_rise),
        .o_fall (sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_csn_sync (
        .i_ck   (i_ck),
        .i_rstn (i_rstn),
        .i_din  (i_csn),
        .o_sync (csn_s),
        .o_rise (csn_rise),
        .o_fall (csn_fall)
    );

    // MOSI only needs a plain synchronizer; it is sampled on SCLK rise detect.
    always_ff @(posedge i_ck or negedge i_rstn) begin
        if (!i_rstn) begin
            mosi_sync_reg <= '0;
        end else begin
            mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], i_mosi};
        end
    end

    assign mosi_s   = mosi_sync_reg[SYNC_STAGES-1];
    assign rx_shift = {rx_reg[6:0], mosi_s};

    always_ff @(posedge i_ck or negedge i_rstn) begin
        if (!i_rstn) begin
            state_reg     <= ST_IDLE;
            bit_cnt_reg   <= '0;
            rx_reg        <= '0;
            tx_reg        <= '0;
            miso_reg      <= 1'b0;
            overrun_reg   <= 1'b0;
            cmd_rd_reg    <= 1'b0;
            cmd_addr_reg  <= '0;
            bus_addr_reg  <= '0;
            bus_wdata_reg <= '0;
            bus_wr_reg    <= 1'b0;
            bus_rd_reg    <= 1'b0;
            rd_dly_reg    <= 1'b0;
            frame_err_reg <= 1'b0;
            armed_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            bit_cnt_reg   <= bit_cnt_next;
            rx_reg        <= rx_next;
            tx_reg        <= tx_next;
            miso_reg      <= miso_next;
            overrun_reg   <= overrun_next;
            cmd_rd_reg    <= cmd_rd_next;
            cmd_addr_reg  <= cmd_addr_next;
            bus_addr_reg  <= bus_addr_next;
            bus_wdata_reg <= bus_wdata_next;
            bus_wr_reg    <= bus_wr_next;
            bus_rd_reg    <= bus_rd_next;
            rd_dly_reg    <= rd_dly_next;
            frame_err_reg <= frame_err_next;
            armed_reg     <= armed_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        bit_cnt_next   = bit_cnt_reg;
        rx_next        = rx_reg;
        tx_next        = tx_reg;
        miso_next      = miso_reg;
        overrun_next   = overrun_reg;
        cmd_rd_next    = cmd_rd_reg;
        cmd_addr_next  = cmd_addr_reg;
        bus_addr_next  = bus_addr_reg;
        bus_wdata_next = bus_wdata_reg;
        bus_wr_next    = 1'b0;
        bus_rd_next    = 1'b0;
        rd_dly_next    = bus_rd_reg;
        frame_err_next = 1'b0;
        armed_next     = armed_reg | csn_s;

        // Register file answers one cycle after the read strobe.
        if (rd_dly_reg) begin
            tx_next = i_bus_rdata;
        end

        if (csn_rise) begin
            if (state_reg != ST_IDLE) begin
                if (state_reg == ST_DONE && !overrun_reg) begin
                    if (!cmd_rd_reg) begin
                        bus_wr_next    = 1'b1;
                        bus_addr_next  = cmd_addr_reg;
                        bus_wdata_next = rx_reg;
                    end
                end else begin
                    frame_err_next = 1'b1;
                end
            end
            state_next   = ST_IDLE;
            miso_next    = 1'b0;
            overrun_next = 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (csn_fall) begin
                        state_next   = ST_CMD;
                        bit_cnt_next = '0;
                        rx_next      = '0;
                        tx_next      = '0;
                        miso_next    = 1'b0;
                        overrun_next = 1'b0;
                    end
                end
                ST_CMD: begin
                    if (sclk_rise) begin
                        rx_next      = rx_shift;
                        bit_cnt_next = bit_cnt_reg + 5'd1;
                        if (bit_cnt_reg == 5'(CMD_BITS - 1)) begin
                            state_next    = ST_DATA;
                            cmd_rd_next   = rx_shift[READ_FLAG_BIT];
                            cmd_addr_next = rx_shift[ADDR_W-1:0];
                            if (rx_shift[READ_FLAG_BIT]) begin
                                bus_rd_next   = 1'b1;
                                bus_addr_next = rx_shift[ADDR_W-1:0];
                            end
                        end
                    end
                end
                ST_DATA: begin
                    if (sclk_fall) begin
                        miso_next = tx_reg[7];
                        tx_next   = {tx_reg[6:0], 1'b0};
                    end
                    if (sclk_rise) begin
                        rx_next      = rx_shift;
                        bit_cnt_next = bit_cnt_reg + 5'd1;
                        if (bit_cnt_reg == 5'(FRAME_BITS - 1)) begin
                            state_next = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (sclk_rise) begin
                        overrun_next = 1'b1;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // SCLK level itself is not needed beyond its edges.
    logic unused_sclk;
    assign unused_sclk = sclk_s;

    assign o_miso      = miso_reg;
    assign o_miso_oe   = armed_reg & ~csn_s;
    assign o_bus_addr  = bus_addr_reg;
    assign o_bus_wdata = bus_wdata_reg;
    assign o_bus_wr    = bus_wr_reg;
    assign o_bus_rd    = bus_rd_reg;
    assign o_busy      = (state_reg != ST_IDLE);
    assign o_frame_err = frame_err_reg;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed bench for spi_reg_bridge: an SPI master task drives frames,
// expected bus events go to a scoreboard checked by a strobe monitor.
module tb_spi_reg_bridge;

    localparam int HALF = 10;

    logic       ck = 1'b0;
    logic       rstn;
    logic       sclk;
    logic       csn;
    logic       mosi;
    logic       miso;
    logic       miso_oe;
    logic [6:0] bus_addr;
    logic [7:0] bus_wdata;
    logic       bus_wr;
    logic       bus_rd;
    logic [7:0] bus_rdata;
    logic       busy;
    logic       frame_err;

    int checks = 0;
    int errors = 0;

    typedef enum int {K_WR, K_RD, K_ERR} kind_e;
    typedef struct {
        kind_e      kind;
        logic [6:0] addr;
        logic [7:0] data;
    } ev_t;
    ev_t sb[$];

    always #5 ck = ~ck;

    spi_reg_bridge #(.SYNC_STAGES(2), .ADDR_W(7)) dut (
        .i_ck        (ck),
        .i_rstn      (rstn),
        .i_sclk      (sclk),
        .i_csn       (csn),
        .i_mosi      (mosi),
        .o_miso      (miso),
        .o_miso_oe   (miso_oe),
        .o_bus_addr  (bus_addr),
        .o_bus_wdata (bus_wdata),
        .o_bus_wr    (bus_wr),
        .o_bus_rd    (bus_rd),
        .i_bus_rdata (bus_rdata),
        .o_busy      (busy),
        .o_frame_err (frame_err)
    );

    // Peripheral register file: unwritten addresses return addr ^ 0x3F.
    logic [7:0]   regs [0:127];
    logic [127:0] written;
    always @(posedge ck or negedge rstn) begin
        if (!rstn) begin
            written   <= '0;
            bus_rdata <= '0;
        end else begin
            if (bus_wr) begin
                regs[bus_addr]    <= bus_wdata;
                written[bus_addr] <= 1'b1;
            end
            if (bus_rd) begin
                bus_rdata <= written[bus_addr] ? regs[bus_addr] : ({1'b0, bus_addr} ^ 8'h3F);
            end
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input kind_e k, input logic [6:0] a, input logic [7:0] d);
        ev_t e;
        e.kind = k;
        e.addr = a;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic check_ev(input kind_e k, input logic [6:0] a, input logic [7:0] d);
        ev_t e;
        chk("strobe_expected", 16'(sb.size() != 0), 16'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("strobe_kind", 16'(k), 16'(e.kind));
            if (k != K_ERR) chk("strobe_addr", 16'(a), 16'(e.addr));
            if (k == K_WR)  chk("strobe_wdata", 16'(d), 16'(e.data));
        end
        $display("txn kind=%0d addr=%h data=%h t=%0t", k, a, d, $time);
    endtask

    always @(negedge ck) begin
        if (rstn) begin
            if (bus_wr)    check_ev(K_WR, bus_addr, bus_wdata);
            if (bus_rd)    check_ev(K_RD, bus_addr, 8'h00);
            if (frame_err) check_ev(K_ERR, 7'h00, 8'h00);
            if (bus_wr || frame_err) chk("wr_err_exclusive", 16'(bus_wr & frame_err), 16'd0);
        end
    end

    task automatic half();
        repeat (HALF) @(negedge ck);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_miso"}, 16'(miso), 16'd0);
        chk({tag, "_oe"}, 16'(miso_oe), 16'd0);
        chk({tag, "_addr"}, 16'(bus_addr), 16'd0);
        chk({tag, "_wdata"}, 16'(bus_wdata), 16'd0);
        chk({tag, "_wr"}, 16'(bus_wr), 16'd0);
        chk({tag, "_rd"}, 16'(bus_rd), 16'd0);
        chk({tag, "_busy"}, 16'(busy), 16'd0);
        chk({tag, "_err"}, 16'(frame_err), 16'd0);
    endtask

    // Mode-3 master: change MOSI on fall, sample MISO on rise.
    task automatic frame(input logic [7:0] cmd, input logic [7:0] dat, input int nrises,
                         input int rst_at, input logic exp_rd, input logic [7:0] exp_miso);
        logic [15:0] word;
        logic        e;
        word = {cmd, dat};
        @(negedge ck);
        csn = 1'b0;
        half();
        for (int i = 0; i < nrises; i++) begin
            sclk = 1'b0;
            if (i < 16) mosi = word[15-i];
            else        mosi = 1'b0;
            half();
            sclk = 1'b1;
            e = 1'b0;
            if (exp_rd && i >= 8 && i < 16) e = exp_miso[15-i];
            chk($sformatf("miso_rise%0d", i + 1), 16'(miso), 16'(e));
            if (rst_at == 0 || i < rst_at) begin
                chk("busy_in_frame", 16'(busy), 16'd1);
                chk("oe_in_frame", 16'(miso_oe), 16'd1);
            end else begin
                chk("busy_after_rst", 16'(busy), 16'd0);
                chk("oe_after_rst", 16'(miso_oe), 16'd0);
            end
            half();
            if (rst_at == i + 1) begin
                rstn = 1'b0;
                #1;
                chk_reset_outputs("midrst");
                repeat (3) @(negedge ck);
                rstn = 1'b1;
            end
        end
        csn = 1'b1;
    endtask

    task automatic drain(input string tag);
        for (int c = 0; c < 100 && sb.size() != 0; c++) @(negedge ck);
        chk({tag, "_drained"}, 16'(sb.size()), 16'd0);
        repeat (10) @(negedge ck);
        chk({tag, "_idle_busy"}, 16'(busy), 16'd0);
        chk({tag, "_idle_miso"}, 16'(miso), 16'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0;
        csn  = 1'b1;
        sclk = 1'b1;
        mosi = 1'b0;
        repeat (4) @(negedge ck);
        chk_reset_outputs("in_rst");
        rstn = 1'b1;
        repeat (10) @(negedge ck);
        chk_reset_outputs("post_rst");

        // SCLK/MOSI activity with CSN high must do nothing.
        for (int k = 0; k < 10; k++) begin
            sclk = 1'b0;
            mosi = 1'($urandom);
            repeat (3) @(negedge ck);
            sclk = 1'b1;
            repeat (3) @(negedge ck);
        end
        mosi = 1'b0;
        drain("csn_high_toggle");

        push(K_WR, 7'h05, 8'hA5);
        frame(8'h05, 8'hA5, 16, 0, 1'b0, 8'h00);
        drain("write05");

        push(K_RD, 7'h03, 8'h00);
        frame(8'h83, 8'h00, 16, 0, 1'b1, 8'h3C);
        drain("read03");

        push(K_RD, 7'h05, 8'h00);
        frame(8'h85, 8'hFF, 16, 0, 1'b1, 8'hA5);
        drain("read05");

        push(K_ERR, 7'h00, 8'h00);
        frame(8'h07, 8'h99, 10, 0, 1'b0, 8'h00);
        drain("abort10");

        push(K_ERR, 7'h00, 8'h00);
        frame(8'h06, 8'h11, 17, 0, 1'b0, 8'h00);
        drain("overrun17");

        frame(8'h09, 8'h77, 16, 12, 1'b0, 8'h00);
        drain("rst_midframe");

        push(K_WR, 7'h10, 8'h5A);
        frame(8'h10, 8'h5A, 16, 0, 1'b0, 8'h00);
        drain("write10");

        // Minimum CSN-high gap with SCLK toggling inside it.
        push(K_WR, 7'h21, 8'hC3);
        push(K_WR, 7'h7F, 8'h0F);
        frame(8'h21, 8'hC3, 16, 0, 1'b0, 8'h00);
        @(negedge ck);
        sclk = 1'b0;
        @(negedge ck);
        sclk = 1'b1;
        @(negedge ck);
        frame(8'h7F, 8'h0F, 16, 0, 1'b0, 8'h00);
        drain("back_to_back");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_reg_bridge.md
# spi_reg_bridge

SPI slave-side bridge that terminates the 16-bit frames produced by the team's SPI master: an 8-bit command/address byte followed by an 8-bit data byte, MSB first, SCLK idle high, data changed on falling edges and sampled on rising edges (mode 3). It oversamples SCLK/CSN/MOSI with the local clock and turns each frame into a single local-bus write or read. The local side connects to a peripheral register file. On read frames it returns the register byte on MISO during the data byte.

## Interface
- SYNC_STAGES, 2: flip-flop stages on each of i_sclk, i_csn, i_mosi (minimum 2).
- ADDR_W, 7: local-bus address width; taken from command byte bits [ADDR_W-1:0], ADDR_W ≤ 7.

- i_ck  input  1  local clock; must be at least 16× the SCLK frequency.
- i_rstn  input  1  reset, asynchronous, active-low.
- i_sclk  input  1  SPI clock from master, idle high.
- i_csn  input  1  SPI chip select, active low.
- i_mosi  input  1  SPI data from master.
- o_miso  output  1  SPI data to master.
- o_miso_oe  output  1  MISO output enable; high while synchronized CSN is low.
- o_bus_addr  output  ADDR_W  local register address.
- o_bus_wdata  output  8  local write data.
- o_bus_wr  output  1  one-cycle write strobe.
- o_bus_rd  output  1  one-cycle read strobe.
- i_bus_rdata  input  8  read data, valid exactly one i_ck cycle after o_bus_rd.
- o_busy  output  1  high from CSN-fall detect to CSN-rise detect.
- o_frame_err  output  1  one-cycle pulse on a malformed frame.

## Operation
- Command byte: bit 7 = 1 read, 0 write; bits [ADDR_W-1:0] = address; unused bits ignored.
- Synchronize all three SPI inputs; detect edges on the synchronized SCLK and CSN.
- States: IDLE, CMD, DATA, DONE.
- IDLE: CSN fall -> CMD; clear the bit counter (5 bits) and the RX shift register.
- CMD: each SCLK rise shifts MOSI into RX. The 8th rise latches the command and enters DATA.
- On entering DATA with the read flag set: assert o_bus_rd with o_bus_addr in the next cycle. One cycle later, load i_bus_rdata into the TX shift register.
- DATA: each SCLK fall drives o_miso = TX[7], then shifts TX left (zero fill). Each SCLK rise shifts MOSI into RX. The 16th rise enters DONE.
- On a write frame, MISO stays 0.
- DONE: further SCLK rises set an overrun flag and are otherwise ignored.
- CSN rise in DONE with no overrun on a write frame: pulse o_bus_wr for one cycle with the latched address and data byte.
- CSN rise with fewer than 16 rises, or with overrun: pulse o_frame_err, issue no write, return to IDLE. A read already issued is not undone.
- CSN rise in any state returns to IDLE. o_miso returns to 0.
- SCLK edges while CSN is high are ignored.

## Timing
- Reset values: o_miso 0, o_miso_oe 0, o_bus_addr 0, o_bus_wdata 0, o_bus_wr 0, o_bus_rd 0, o_busy 0, o_frame_err 0. State is IDLE; all shift registers and counters are 0.
- Input-to-detect latency: SYNC_STAGES+1 i_ck cycles from a pin edge to internal edge detect.
- Read path timing:
  - o_bus_rd fires 1 cycle after the 8th-rise detect.
  - TX is loaded 2 cycles after that detect.
  - The 16× clock ratio guarantees TX is loaded before the 9th SCLK fall is detected.
- o_bus_wr and o_frame_err assert 1 cycle after CSN-rise detect. They are mutually exclusive.
- o_bus_addr/o_bus_wdata hold their values until the next strobe.
- Back-to-back frames: CSN high for at least SYNC_STAGES+2 i_ck cycles is required between frames. A new CSN fall is accepted in the cycle after the strobe.
- Reset mid-frame: all outputs return to reset values immediately and no strobe is issued. After reset release, an in-progress frame is ignored until CSN goes high, then low.

## Structure
- Shared package spi_pkg:
  - state encoding for IDLE/CMD/DATA/DONE;
  - FRAME_BITS = 16 and CMD_BITS = 8;
  - READ_FLAG_BIT = 7.
- The SPI master uses the same package for its frame constants.
- One sub-module, spi_sync_edge: an N-stage synchronizer with registered rise/fall pulses. It is instantiated for SCLK and CSN; MOSI uses the synchronizer only.

## Test plan
- Write frame 0x05, 0xA5 at SCLK = i_ck/20 -> one o_bus_wr pulse after CSN rise, addr 0x05, wdata 0xA5, o_frame_err 0, o_miso 0 throughout.
- Read frame 0x83 with i_bus_rdata = 0x3C -> o_bus_rd pulse with addr 0x03 after the 8th rise; MISO sampled on rises 9–16 reads 0,0,1,1,1,1,0,0; no o_bus_wr.
- Frame aborted after 10 SCLK rises -> o_frame_err pulse, no o_bus_wr, state IDLE, o_busy 0.
- Write frame with 17 SCLK rises -> o_frame_err pulse, no o_bus_wr.
- i_rstn low after 12 bits of a write frame, released while CSN is still low -> no strobes. The next full frame 0x10, 0x5A is written correctly.
- Two write frames separated by a minimum CSN-high gap -> two o_bus_wr pulses with correct addr/data; SCLK toggling while CSN is high has no effect.
